// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates trap/branch/jump redirects and drives PC load, hold and flush controls
module pc_redirect_ctrl #(
  parameter int XLEN       = 32,
  parameter int TRAP_DRAIN = 3
) (
  input  logic            clk,
  input  logic            resetIn,
  input  logic            stall,
  input  logic            trapReq,
  input  logic [XLEN-1:0] trapVec,
  input  logic            exBrValid,
  input  logic [XLEN-1:0] exBrTarget,
  input  logic            idJmpValid,
  input  logic [XLEN-1:0] idJmpTarget,
  output logic            locker,
  output logic            select,
  output logic [XLEN-1:0] addrJump,
  output logic            flushIF_ID,
  output logic            flushID_EX,
  output logic            busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  // Source codes are ordered so a numerically larger code means higher priority.
  localparam logic [1:0] S_NONE = 2'd0;
  localparam logic [1:0] S_ID   = 2'd1;
  localparam logic [1:0] S_EX   = 2'd2;
  localparam logic [1:0] S_TRAP = 2'd3;
  localparam logic [3:0] DRAIN_INIT = 4'(TRAP_DRAIN);
  localparam logic [1:0] TRAP_STATE = (TRAP_DRAIN == 0) ? PEND : DRAIN;
  logic [1:0]      state, state_n, src, src_n, req_src;
  logic [XLEN-1:0] tgt_n, req_tgt;
  logic [3:0]      cnt, cnt_n;
  logic            consume, first_drain;
  assign req_src = trapReq ? S_TRAP : exBrValid ? S_EX : idJmpValid ? S_ID : S_NONE;
  assign req_tgt = trapReq ? trapVec : exBrValid ? exBrTarget : idJmpTarget;
  assign locker = !stall && state != DRAIN;
  assign select = state == PEND;
  assign consume = select && locker;
  assign first_drain = state == DRAIN && cnt == DRAIN_INIT;
  assign flushIF_ID = consume || first_drain;
  assign flushID_EX = (consume && (src == S_EX || src == S_TRAP)) || first_drain;
  assign busy = state != IDLE;
  // Next-state: drain countdown, trap capture, consume retirement, or priority capture/replace.
  // The trap vector is latched into the target at capture so it is ready when the drain ends.
  always_comb begin
    state_n = state;
    src_n   = src;
    tgt_n   = addrJump;
    cnt_n   = cnt;
    if (state == DRAIN) begin
      cnt_n   = cnt - 4'd1;
      state_n = (cnt <= 4'd1) ? PEND : DRAIN;
    end else if (trapReq && (state == IDLE || consume)) begin
      state_n = TRAP_STATE;
      src_n   = S_TRAP;
      tgt_n   = trapVec;
      cnt_n   = DRAIN_INIT;
    end else if (consume) begin
      state_n = IDLE;
      src_n   = S_NONE;
    end else if (req_src > src) begin
      state_n = PEND;
      src_n   = req_src;
      tgt_n   = req_tgt;
    end
  end
  // State registers with synchronous active-low reset discarding any pending or draining redirect.
  always_ff @(posedge clk) begin
    if (!resetIn) begin
      state    <= IDLE;
      src      <= S_NONE;
      addrJump <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      src      <= src_n;
      addrJump <= tgt_n;
      cnt      <= cnt_n;
    end
  end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;
  logic        clk = 1'b0;
  logic        resetIn, stall, trapReq, exBrValid, idJmpValid;
  logic [31:0] trapVec, exBrTarget, idJmpTarget, addrJump;
  logic        locker, select, flushIF_ID, flushID_EX, busy;
  int          tests = 0;
  int          fails = 0;

  pc_redirect_ctrl #(.XLEN(32), .TRAP_DRAIN(3)) dut (
    .clk(clk), .resetIn(resetIn), .stall(stall), .trapReq(trapReq), .trapVec(trapVec),
    .exBrValid(exBrValid), .exBrTarget(exBrTarget), .idJmpValid(idJmpValid),
    .idJmpTarget(idJmpTarget), .locker(locker), .select(select), .addrJump(addrJump),
    .flushIF_ID(flushIF_ID), .flushID_EX(flushID_EX), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetIn = 0; stall = 0; trapReq = 0; exBrValid = 1; idJmpValid = 0;
    trapVec = 32'h200; exBrTarget = 32'h100; idJmpTarget = 32'h40;
    step(); step();
    chk("rst_select", 32'(select), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", addrJump, 0);
    chk("rst_locker", 32'(locker), 1);
    exBrValid = 0; resetIn = 1; stall = 1; #1;
    chk("rel_locker_stall", 32'(locker), 0);
    stall = 0; #1;
    chk("rel_locker", 32'(locker), 1);

    exBrValid = 1; exBrTarget = 32'h100; step(); exBrValid = 0;
    chk("ex_select", 32'(select), 1);
    chk("ex_locker", 32'(locker), 1);
    chk("ex_addr", addrJump, 32'h100);
    chk("ex_fif", 32'(flushIF_ID), 1);
    chk("ex_fid", 32'(flushID_EX), 1);
    step();
    chk("ex_idle_sel", 32'(select), 0);
    chk("ex_idle_busy", 32'(busy), 0);
    chk("ex_idle_fif", 32'(flushIF_ID), 0);

    idJmpValid = 1; idJmpTarget = 32'h40; stall = 1; step(); idJmpValid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("id_hold_sel", 32'(select), 1);
      chk("id_hold_addr", addrJump, 32'h40);
      chk("id_hold_lock", 32'(locker), 0);
      chk("id_hold_fif", 32'(flushIF_ID), 0);
      if (i < 2) step();
    end
    stall = 0; #1;
    chk("id_cons_lock", 32'(locker), 1);
    chk("id_cons_fif", 32'(flushIF_ID), 1);
    chk("id_cons_fid", 32'(flushID_EX), 0);
    step();
    chk("id_idle", 32'(busy), 0);

    idJmpValid = 1; idJmpTarget = 32'h40; exBrValid = 1; exBrTarget = 32'h80; step();
    idJmpValid = 0; exBrValid = 0;
    chk("prio_addr", addrJump, 32'h80);
    chk("prio_fid", 32'(flushID_EX), 1);
    step();
    chk("prio_idle", 32'(busy), 0);
    stall = 1; idJmpValid = 1; idJmpTarget = 32'h40; step(); idJmpValid = 0;
    chk("repl_before", addrJump, 32'h40);
    exBrValid = 1; exBrTarget = 32'h80; step(); exBrValid = 0;
    chk("repl_after", addrJump, 32'h80);
    chk("repl_sel", 32'(select), 1);
    idJmpValid = 1; idJmpTarget = 32'h44; step(); idJmpValid = 0;
    chk("lower_dropped", addrJump, 32'h80);
    stall = 0; #1;
    chk("repl_fid", 32'(flushID_EX), 1);
    step();
    chk("repl_idle", 32'(busy), 0);

    trapReq = 1; trapVec = 32'h200; step(); trapReq = 0;
    exBrValid = 1; exBrTarget = 32'h300;
    chk("trap_d1_lock", 32'(locker), 0);
    chk("trap_d1_fif", 32'(flushIF_ID), 1);
    chk("trap_d1_fid", 32'(flushID_EX), 1);
    chk("trap_d1_busy", 32'(busy), 1);
    chk("trap_d1_sel", 32'(select), 0);
    step();
    chk("trap_d2_lock", 32'(locker), 0);
    chk("trap_d2_fif", 32'(flushIF_ID), 0);
    chk("trap_d2_fid", 32'(flushID_EX), 0);
    step();
    chk("trap_d3_lock", 32'(locker), 0);
    chk("trap_d3_sel", 32'(select), 0);
    step(); exBrValid = 0;
    chk("trap_sel", 32'(select), 1);
    chk("trap_addr", addrJump, 32'h200);
    chk("trap_lock", 32'(locker), 1);
    chk("trap_fid", 32'(flushID_EX), 1);
    step();
    chk("trap_idle", 32'(busy), 0);
    chk("trap_idle_sel", 32'(select), 0);

    trapReq = 1; trapVec = 32'h200; step(); trapReq = 0;
    step();
    resetIn = 0; step(); resetIn = 1;
    chk("drst_busy", 32'(busy), 0);
    chk("drst_sel", 32'(select), 0);
    chk("drst_addr", addrJump, 0);
    chk("drst_lock", 32'(locker), 1);
    step(); step(); step();
    chk("drst_no_redir", 32'(select), 0);
    chk("drst_still_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
